// File: rtl/sha256_msg_schedule_if.sv
// Handshake and data bundle between the SHA-256 round controller
// and the message-schedule stage.
//
// master (controller side) drives:
//   start, block_in, step
// slave (schedule side) drives:
//   w_out, w_valid, round, busy, done
interface sha256_msg_schedule_if #(
    parameter int WORD_W = 32
);
    logic                  start;
    logic [16*WORD_W-1:0]  block_in;
    logic                  step;
    logic [WORD_W-1:0]     w_out;
    logic                  w_valid;
    logic [5:0]            round;
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output block_in,
        output step,
        input  w_out,
        input  w_valid,
        input  round,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  block_in,
        input  step,
        output w_out,
        output w_valid,
        output round,
        output busy,
        output done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and emits
// W[0..63], one word per controller step, from a 16-word window.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of sha256_msg_schedule_if
//           (start/block_in/step in; w_out/w_valid/round/busy/done out)
module sha256_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha256_msg_schedule_if.slave    bus
);

    if (WORD_W != 32) begin : g_bad_word_w
        $error("sha256_msg_schedule: WORD_W must be 32");
    end
    if (ROUNDS != 64) begin : g_bad_rounds
        $error("sha256_msg_schedule: ROUNDS must be 64");
    end

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    function automatic logic [WORD_W-1:0] sig0(
        input logic [WORD_W-1:0] x
    );
        return {x[6:0],  x[31:7]}
             ^ {x[17:0], x[31:18]}
             ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(
        input logic [WORD_W-1:0] x
    );
        return {x[16:0], x[31:17]}
             ^ {x[18:0], x[31:19]}
             ^ (x >> 10);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [5:0]        round_q, round_d;
    logic              done_q,  done_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [WORD_W-1:0] w_next;

    // win[0] is W[t]; win[15] is W[t+15].  The next word W[t+16]
    // depends only on words already held in the window.
    assign w_next = sig1(win_q[14]) + win_q[9]
                  + sig0(win_q[1])  + win_q[0];

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                // step is deliberately not looked at here, so a
                // start+step cycle is a pure load.
                if (bus.start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = bus.block_in[
                            16*WORD_W-1 - WORD_W*i -: WORD_W];
                    end
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.step) begin
                    if (round_q == LAST_ROUND) begin
                        // Window is left as-is after the last word.
                        state_d = ST_IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[15] = w_next;
                        round_d   = round_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.w_out   = win_q[0];
    assign bus.w_valid = (state_q == ST_RUN);
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.round   = round_q;
    assign bus.done    = done_q;

endmodule
